// File: rtl/mem_access_sequencer.sv
// Four-core round-robin sequencer driving the 13-bit mem_ctrl word
// (DR load, AR select, data select, DRAM wren) for the shared DRAM.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req[3:0]  per-core request, held until the matching done pulse
//   we[3:0]   per-core write qualifier, sampled at grant
//   mem_ctrl  [3:0] DR wren, [7:4] AR sel, [11:8] data sel, [12] DRAM wren
//   done[3:0] one-cycle completion pulse per core
//   busy      high while an access is in progress
module mem_access_sequencer #(
    parameter int RD_LAT = 1
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [3:0]  req,
    input  logic [3:0]  we,
    output logic [12:0] mem_ctrl,
    output logic [3:0]  done,
    output logic        busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_READ,
        S_LOAD,
        S_WRITE
    } state_t;

    state_t      r_state;
    logic [1:0]  r_g;
    logic [1:0]  r_cnt;
    logic [1:0]  r_ptr;
    logic [12:0] r_mc;
    logic [3:0]  r_done;
    logic        r_busy;

    state_t      w_nstate;
    logic [1:0]  w_ng;
    logic [1:0]  w_ncnt;
    logic [1:0]  w_nptr;
    logic [12:0] w_nmc;
    logic [3:0]  w_ndone;
    logic [3:0]  w_elig;
    logic [3:0]  w_sel;
    logic [1:0]  w_idx;
    logic [1:0]  w_gnt;
    logic        w_found;

    // Rotating priority search starting at the pointer; the core being
    // acknowledged this cycle is masked so it cannot be re-granted at once.
    always_comb begin
        w_elig  = req & ~r_done;
        w_found = 1'b0;
        w_gnt   = r_ptr;
        w_idx   = r_ptr;
        for (int k = 0; k < 4; k++) begin
            w_idx = r_ptr + 2'(k);
            if (!w_found && w_elig[w_idx]) begin
                w_found = 1'b1;
                w_gnt   = w_idx;
            end
        end
    end

    always_comb begin
        w_nstate = r_state;
        w_ng     = r_g;
        w_ncnt   = r_cnt;
        w_nptr   = r_ptr;
        w_ndone  = 4'b0000;
        unique case (r_state)
            S_IDLE: begin
                if (w_found) begin
                    w_ng     = w_gnt;
                    w_nptr   = w_gnt + 2'd1;
                    w_ncnt   = 2'(RD_LAT - 1);
                    w_nstate = we[w_gnt] ? S_WRITE : S_READ;
                end
            end
            S_READ: begin
                if (r_cnt == 2'd0) begin
                    w_nstate = S_LOAD;
                end else begin
                    w_ncnt = r_cnt - 2'd1;
                end
            end
            S_LOAD: begin
                w_nstate = S_IDLE;
                w_ndone  = 4'b0001 << r_g;
            end
            S_WRITE: begin
                w_nstate = S_IDLE;
                w_ndone  = 4'b0001 << r_g;
            end
            default: w_nstate = S_IDLE;
        endcase
    end

    // Outputs are decoded from the next state so they register in
    // lock-step with it.
    always_comb begin
        w_sel = 4'b0001 << w_ng;
        w_nmc = '0;
        unique case (w_nstate)
            S_READ:  w_nmc = {5'b0, w_sel, 4'b0};
            S_LOAD:  w_nmc = {5'b0, w_sel, w_sel};
            S_WRITE: w_nmc = {1'b1, w_sel, w_sel, 4'b0};
            default: w_nmc = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
            r_g     <= 2'd0;
            r_cnt   <= 2'd0;
            r_ptr   <= 2'd0;
            r_mc    <= '0;
            r_done  <= 4'b0000;
            r_busy  <= 1'b0;
        end else begin
            r_state <= w_nstate;
            r_g     <= w_ng;
            r_cnt   <= w_ncnt;
            r_ptr   <= w_nptr;
            r_mc    <= w_nmc;
            r_done  <= w_ndone;
            r_busy  <= (w_nstate != S_IDLE);
        end
    end

    assign mem_ctrl = r_mc;
    assign done     = r_done;
    assign busy     = r_busy;

endmodule
